// File: rtl/mcp3_fifo512x080_ctl.sv
// mcp3_fifo512x080_ctl: first-word-fall-through controller for an external 512x80 SDP RAM with a 1-cycle registered read.
// Ports: push_valid/push_data/push_ready (producer side), pop_valid/pop_data/pop_ready (consumer side),
// ram_wren/ram_wrad/ram_data and ram_rden/ram_rdad/ram_q (RAM side), occupancy (RAM + in flight + output stage),
// afull (almost full, present only with MCP3_FIFO_AFULL_EN defined), coll_err (sticky same-address read/write flag).
// Optional feature macro: MCP3_FIFO_AFULL_EN enables the registered afull comparator against AFULL_THRESH.
module mcp3_fifo512x080_ctl #(
  parameter int AFULL_THRESH = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push_valid,
  input  logic [79:0] push_data,
  output logic        push_ready,
  output logic        pop_valid,
  output logic [79:0] pop_data,
  input  logic        pop_ready,
  output logic        ram_wren,
  output logic [8:0]  ram_wrad,
  output logic [79:0] ram_data,
  output logic        ram_rden,
  output logic [8:0]  ram_rdad,
  input  logic [79:0] ram_q,
  output logic [9:0]  occupancy,
  output logic        afull,
  output logic        coll_err
);
  logic [8:0]  r_wr_ptr, r_rd_ptr;
  logic [9:0]  r_ram_cnt, r_occ;
  logic        r_inflight, r_coll;
  logic [1:0]  r_ost_cnt;
  logic [79:0] r_ost0, r_ost1;
  logic        w_accept, w_take, w_rd_issue;
  logic [2:0]  w_pending;
  logic [1:0]  w_cnt_p, w_ost_cnt_nxt;
  logic [9:0]  w_ram_cnt_nxt, w_occ_nxt;
  assign push_ready = r_ram_cnt != 10'd512;
  assign w_accept   = push_valid & push_ready;
  assign pop_valid  = r_ost_cnt != 2'd0;
  assign pop_data   = r_ost0;
  assign w_take     = pop_valid & pop_ready;
  // words already committed to the output stage after this cycle's pop; never negative because a pop implies ost_cnt >= 1
  assign w_pending  = {1'b0, r_ost_cnt} + {2'b0, r_inflight} - {2'b0, w_take};
  assign w_rd_issue = (r_ram_cnt != 10'd0) & (w_pending < 3'd2);
  assign ram_wren   = w_accept;
  assign ram_wrad   = r_wr_ptr;
  assign ram_data   = push_data;
  assign ram_rden   = w_rd_issue;
  assign ram_rdad   = r_rd_ptr;
  assign w_cnt_p       = r_ost_cnt - {1'b0, w_take};
  assign w_ost_cnt_nxt = w_cnt_p + {1'b0, r_inflight};
  assign w_ram_cnt_nxt = r_ram_cnt + 10'(w_accept) - 10'(w_rd_issue);
  assign w_occ_nxt     = w_ram_cnt_nxt + 10'(w_rd_issue) + 10'(w_ost_cnt_nxt);
  assign occupancy     = r_occ;
  assign coll_err      = r_coll;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_ost_cnt  <= '0;
      r_ost0     <= '0;
      r_ost1     <= '0;
      r_occ      <= '0;
      r_coll     <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + 9'(w_accept);
      r_rd_ptr   <= r_rd_ptr + 9'(w_rd_issue);
      r_ram_cnt  <= w_ram_cnt_nxt;
      r_inflight <= w_rd_issue;
      r_ost_cnt  <= w_ost_cnt_nxt;
      // head only changes on capture into an empty slot or a shift, so pop_data holds its last value when empty
      r_ost0     <= (r_inflight && w_cnt_p == 2'd0) ? ram_q : (w_take && r_ost_cnt == 2'd2) ? r_ost1 : r_ost0;
      r_ost1     <= (r_inflight && w_cnt_p == 2'd1) ? ram_q : r_ost1;
      r_occ      <= w_occ_nxt;
      r_coll     <= r_coll | (w_accept & w_rd_issue & (r_wr_ptr == r_rd_ptr));
    end
  end
`ifdef MCP3_FIFO_AFULL_EN
  logic r_afull;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_afull <= 1'b0;
    else r_afull <= {1'b0, w_occ_nxt} >= 11'(AFULL_THRESH);
  end
  assign afull = r_afull;
`else
  assign afull = 1'b0;
`endif
endmodule
